// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded operands from ID, forwarding sources from EX/MEM and MEM/WB,
// and the registered/forwarded operands handed to the ALU.
interface id_ex_if #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUFUN_W = 6
);
    logic                id_valid;
    logic [DATA_W-1:0]   id_rs_data;
    logic [DATA_W-1:0]   id_rt_data;
    logic [DATA_W-1:0]   id_imm;
    logic [4:0]          id_shamt;
    logic [RADDR_W-1:0]  id_rs_addr;
    logic [RADDR_W-1:0]  id_rt_addr;
    logic [RADDR_W-1:0]  id_rd_addr;
    logic [ALUFUN_W-1:0] id_alufun;
    logic                id_alusrc1;
    logic                id_alusrc2;
    logic                id_regwrite;

    logic                exmem_regwrite;
    logic [RADDR_W-1:0]  exmem_rd;
    logic [DATA_W-1:0]   exmem_result;
    logic                memwb_regwrite;
    logic [RADDR_W-1:0]  memwb_rd;
    logic [DATA_W-1:0]   memwb_result;

    logic                ex_valid;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [ALUFUN_W-1:0] ex_alufun;
    logic [DATA_W-1:0]   ex_store_data;
    logic [RADDR_W-1:0]  ex_rd;
    logic                ex_regwrite;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs_addr, id_rt_addr,
               id_rd_addr, id_alufun, id_alusrc1, id_alusrc2, id_regwrite,
               exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
        input  ex_valid, alu_a, alu_b, ex_alufun, ex_store_data, ex_rd, ex_regwrite
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs_addr, id_rt_addr,
               id_rd_addr, id_alufun, id_alusrc1, id_alusrc2, id_regwrite,
               exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
        output ex_valid, alu_a, alu_b, ex_alufun, ex_store_data, ex_rd, ex_regwrite
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding from EX/MEM and MEM/WB.
// Drives ALU A/B/ALUFun; A carries zero-extended shamt for shift instructions.
module id_ex_stage #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUFUN_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     stall_i,
    input  logic     flush_i,
    id_ex_if.slave   bus
);
    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic                alusrc1;
        logic                alusrc2;
        logic [ALUFUN_W-1:0] alufun;
        logic [RADDR_W-1:0]  rs_addr;
        logic [RADDR_W-1:0]  rt_addr;
        logic [RADDR_W-1:0]  rd;
        logic [4:0]          shamt;
        logic [DATA_W-1:0]   rs_data;
        logic [DATA_W-1:0]   rt_data;
        logic [DATA_W-1:0]   imm;
    } ex_reg_t;

    ex_reg_t           ex_q;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // EX/MEM beats MEM/WB; $zero is never a forwarding target.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (bus.exmem_regwrite && bus.exmem_rd == ex_q.rs_addr && ex_q.rs_addr != '0)
            fwd_rs = bus.exmem_result;
        else if (bus.memwb_regwrite && bus.memwb_rd == ex_q.rs_addr && ex_q.rs_addr != '0)
            fwd_rs = bus.memwb_result;
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (bus.exmem_regwrite && bus.exmem_rd == ex_q.rt_addr && ex_q.rt_addr != '0)
            fwd_rt = bus.exmem_result;
        else if (bus.memwb_regwrite && bus.memwb_rd == ex_q.rt_addr && ex_q.rt_addr != '0)
            fwd_rt = bus.memwb_result;
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            ex_q <= '0;
        end else if (stall_i) begin
            // Latch forwarded operands so a producer retiring mid-stall is not lost.
            ex_q.rs_data <= fwd_rs;
            ex_q.rt_data <= fwd_rt;
        end else begin
            ex_q.valid    <= bus.id_valid;
            ex_q.regwrite <= bus.id_regwrite & bus.id_valid;
            ex_q.alusrc1  <= bus.id_alusrc1;
            ex_q.alusrc2  <= bus.id_alusrc2;
            ex_q.alufun   <= bus.id_alufun;
            ex_q.rs_addr  <= bus.id_rs_addr;
            ex_q.rt_addr  <= bus.id_rt_addr;
            ex_q.rd       <= bus.id_rd_addr;
            ex_q.shamt    <= bus.id_shamt;
            ex_q.rs_data  <= bus.id_rs_data;
            ex_q.rt_data  <= bus.id_rt_data;
            ex_q.imm      <= bus.id_imm;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.alu_a         = ex_q.alusrc1 ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : fwd_rs;
    assign bus.alu_b         = ex_q.alusrc2 ? ex_q.imm : fwd_rt;
    assign bus.ex_alufun     = ex_q.alufun;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_regwrite   = ex_q.regwrite & ex_q.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX outputs are queued when ID is driven
// and compared one cycle later (or after forwarding inputs change).
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset, stall_i, flush_i;

    id_ex_if #(.DATA_W(32), .RADDR_W(5), .ALUFUN_W(6)) bus ();

    id_ex_stage #(.DATA_W(32), .RADDR_W(5), .ALUFUN_W(6)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [5:0]  fun;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [5:0] FUN_SRA = 6'h23;

    function automatic obs_t mk(input logic v, input logic rw, input logic [5:0] fun,
                                input logic [4:0] rd, input logic [31:0] a, b, sd);
        obs_t o;
        o.valid = v; o.rw = rw; o.fun = fun; o.rd = rd; o.a = a; o.b = b; o.sd = sd;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.ex_valid, bus.ex_regwrite, bus.ex_alufun, bus.ex_rd,
                  bus.alu_a, bus.alu_b, bus.ex_store_data);
    endfunction

    task automatic drive(input logic v, input logic [31:0] rs, rt, imm, input logic [4:0] sh,
                         input logic [4:0] rsa, rta, rda, input logic [5:0] fun,
                         input logic s1, s2, rw);
        bus.id_valid = v;   bus.id_rs_data = rs; bus.id_rt_data = rt; bus.id_imm = imm;
        bus.id_shamt = sh;  bus.id_rs_addr = rsa; bus.id_rt_addr = rta; bus.id_rd_addr = rda;
        bus.id_alufun = fun; bus.id_alusrc1 = s1; bus.id_alusrc2 = s2; bus.id_regwrite = rw;
    endtask

    task automatic clear_fwd();
        bus.exmem_regwrite = 1'b0; bus.exmem_rd = '0; bus.exmem_result = '0;
        bus.memwb_regwrite = 1'b0; bus.memwb_rd = '0; bus.memwb_result = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, e;
        reset = 1'b1;
        drive(1, 32'h10, 32'h20, 32'h0, 5'd0, 5'd1, 5'd2, 5'd3, 6'd1, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('0);
            tick();
            got = sample(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL reset_init: got %h want %h", got, e); end
        end
        reset = 1'b0;
        exp_q.push_back(mk(1, 1, 6'd1, 5'd3, 32'h10, 32'h20, 32'h20));
        tick();
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL reset_load: got %h want %h", got, e); end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('0);
            tick();
            got = sample(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL reset_mid: got %h want %h", got, e); end
        end
        reset = 1'b0;
    endtask

    task automatic test_sra();
        obs_t got, e;
        drive(1, 32'h1234, 32'hFFFFB57B, 32'h0, 5'd3, 5'd0, 5'd8, 5'd9, FUN_SRA, 1, 0, 1);
        exp_q.push_back(mk(1, 1, FUN_SRA, 5'd9, 32'h3, 32'hFFFFB57B, 32'hFFFFB57B));
        tick();
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL sra: got %h want %h", got, e); end
    endtask

    task automatic test_forwarding();
        obs_t got, e;
        drive(1, 32'h99, 32'h66, 32'h0, 5'd0, 5'd5, 5'd6, 5'd2, 6'd0, 0, 0, 1);
        exp_q.push_back(mk(1, 1, 6'd0, 5'd2, 32'h11, 32'h66, 32'h66));
        exp_q.push_back(mk(1, 1, 6'd0, 5'd2, 32'h22, 32'h66, 32'h66));
        tick();
        bus.exmem_regwrite = 1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h11;
        bus.memwb_regwrite = 1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'h22;
        #1;
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL fwd_exmem_prio: got %h want %h", got, e); end
        bus.exmem_regwrite = 0;
        #1;
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL fwd_memwb: got %h want %h", got, e); end
        clear_fwd();

        drive(1, 32'h55, 32'h44, 32'h0, 5'd0, 5'd0, 5'd0, 5'd2, 6'd0, 0, 0, 1);
        exp_q.push_back(mk(1, 1, 6'd0, 5'd2, 32'h55, 32'h44, 32'h44));
        tick();
        bus.exmem_regwrite = 1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h11;
        bus.memwb_regwrite = 1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'h22;
        #1;
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL fwd_reg0: got %h want %h", got, e); end
        clear_fwd();

        drive(1, 32'h1, 32'h2, 32'h1234, 5'd0, 5'd4, 5'd6, 5'd7, 6'd3, 0, 1, 1);
        exp_q.push_back(mk(1, 1, 6'd3, 5'd7, 32'h1, 32'h1234, 32'h77));
        tick();
        bus.exmem_regwrite = 1; bus.exmem_rd = 5'd6; bus.exmem_result = 32'h77;
        #1;
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL fwd_store_imm: got %h want %h", got, e); end
        clear_fwd();
    endtask

    task automatic test_stall();
        obs_t got, e;
        drive(1, 32'h30, 32'h01, 32'h0, 5'd0, 5'd3, 5'd7, 5'd4, 6'd2, 0, 0, 1);
        exp_q.push_back(mk(1, 1, 6'd2, 5'd4, 32'h30, 32'h01, 32'h01));
        tick();
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL stall_pre: got %h want %h", got, e); end
        stall_i = 1;
        bus.memwb_regwrite = 1; bus.memwb_rd = 5'd7; bus.memwb_result = 32'hAB;
        drive(1, 32'h444, 32'h999, 32'h0, 5'd0, 5'd8, 5'd9, 5'd10, 6'd5, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(1, 1, 6'd2, 5'd4, 32'h30, 32'hAB, 32'hAB));
            tick();
            clear_fwd();
            #1;
            got = sample(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL stall_hold%0d: got %h want %h", i, got, e); end
        end
        stall_i = 0;
        exp_q.push_back(mk(1, 1, 6'd5, 5'd10, 32'h444, 32'h999, 32'h999));
        tick();
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL stall_release: got %h want %h", got, e); end
    endtask

    task automatic test_flush();
        obs_t got, e;
        drive(1, 32'hC0, 32'hC1, 32'h0, 5'd0, 5'd1, 5'd2, 5'd12, 6'd9, 0, 0, 1);
        exp_q.push_back(mk(1, 1, 6'd9, 5'd12, 32'hC0, 32'hC1, 32'hC1));
        tick();
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL flush_pre: got %h want %h", got, e); end
        flush_i = 1; stall_i = 1;
        exp_q.push_back('0);
        tick();
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL flush_stall: got %h want %h", got, e); end
        flush_i = 0; stall_i = 0;
        exp_q.push_back(mk(1, 1, 6'd9, 5'd12, 32'hC0, 32'hC1, 32'hC1));
        tick();
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL flush_reload: got %h want %h", got, e); end
        flush_i = 1;
        exp_q.push_back('0);
        tick();
        got = sample(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL flush_only: got %h want %h", got, e); end
        flush_i = 0;
    endtask

    task automatic test_bubble();
        drive(0, 32'h5, 32'h6, 32'h0, 5'd0, 5'd1, 5'd2, 5'd3, 6'd1, 0, 0, 1);
        tick();
        n_cmp++;
        if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_valid: got %b want 0", bus.ex_valid); end
        n_cmp++;
        if (bus.ex_regwrite !== 1'b0) begin n_bad++; $display("FAIL bubble_rw: got %b want 0", bus.ex_regwrite); end
    endtask

    task automatic test_back_to_back();
        obs_t got, e;
        logic [31:0] rs, rt, imm;
        logic [4:0]  sh, rsa, rta, rda;
        logic [5:0]  fun;
        logic        s1, s2, rw;
        for (int i = 0; i < 8; i++) begin
            rs = $urandom; rt = $urandom; imm = $urandom;
            sh = 5'($urandom); rsa = 5'($urandom); rta = 5'($urandom); rda = 5'($urandom);
            fun = 6'($urandom); s1 = 1'($urandom); s2 = 1'($urandom); rw = 1'($urandom);
            drive(1, rs, rt, imm, sh, rsa, rta, rda, fun, s1, s2, rw);
            exp_q.push_back(mk(1, rw, fun, rda, s1 ? {27'd0, sh} : rs, s2 ? imm : rt, rt));
            tick();
            got = sample(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL b2b%0d: got %h want %h", i, got, e); end
        end
    endtask

    initial begin
        reset = 1; stall_i = 0; flush_i = 0;
        clear_fwd();
        drive(0, '0, '0, '0, '0, '0, '0, '0, '0, 0, 0, 0);
        test_reset();
        test_sra();
        test_forwarding();
        test_stall();
        test_flush();
        test_bubble();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
